detect_event_logger: RTL and testbench
======================================

Name: detect_event_logger

Overview:
- Consumes the single-bit `detected` output of the FSM sequence detectors, one stage directly downstream.
- Timestamps every detection with a free-running cycle counter and queues the timestamps in a small FIFO.
- Drains the FIFO over a valid/ready interface.
- Keeps a saturating total detection count and a sticky overflow flag for status readout.

Parameters:
- TS_W, 16: timestamp counter width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, 8: detection counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- detected  input  1  detection strobe from the detector; one event per cycle it is high.
- clear  input  1  synchronous clear of count and overflow; FIFO is not affected.
- ts_valid  output  1  FIFO non-empty; ts_data holds the oldest entry.
- ts_ready  input  1  consumer accepts; a pop occurs when ts_valid && ts_ready.
- ts_data  output  TS_W  head timestamp; 0 when ts_valid=0.
- fifo_level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- count  output  CNT_W  total detections since reset/clear, saturating.
- overflow  output  1  sticky: at least one event dropped because the FIFO was full.

Behaviour:
- Reset, and on every rst cycle: ts counter=0, FIFO emptied (pointers 0), ts_valid=0, ts_data=0, fifo_level=0, count=0, overflow=0. `detected`, `clear` and `ts_ready` are ignored while rst=1.
- Reset mid-operation discards all queued entries; no partial state survives.
- Timestamp counter:
  - The first cycle after rst deasserts has ts=0.
  - Increments by 1 every cycle and wraps from 2^TS_W-1 to 0.
  - An event in cycle k after reset carries timestamp k mod 2^TS_W, i.e. the ts value in the cycle detected=1.
- Push: detected=1 in a cycle requests a push of the current ts.
- Pop: ts_valid && ts_ready in a cycle removes the head at the clock edge.
- Latency and ordering:
  - The FIFO is first-word-fall-through with registered state and no bypass.
  - A push into an empty FIFO makes ts_valid=1 with that timestamp in the next cycle.
  - Entries leave in push order.
- Simultaneous push and pop:
  - Both take effect and fifo_level is unchanged.
  - This is allowed when the FIFO is full (pop-then-push), so no drop occurs.
  - When the FIFO is empty, ts_valid=0, so no pop happens and only the push takes effect.
- Full and no pop with detected=1: the event is dropped, FIFO contents are unchanged, and overflow is set to 1.
- Empty: ts_valid=0 and ts_data=0; ts_ready is ignored.
- Pointer wrap: read/write pointers wrap modulo DEPTH. Full and empty are distinguished by fifo_level, or an extra pointer bit.
- count:
  - Increments on every detected=1 cycle, including dropped events.
  - Saturates at 2^CNT_W-1 and never wraps.
- overflow: once set, it stays set until clear or rst.
- clear=1:
  - count becomes (detected ? 1 : 0).
  - overflow becomes 1 only if that same cycle drops an event, else 0.
  - FIFO and ts counter are unaffected.
- Outputs ts_valid, ts_data, fifo_level, count and overflow are all derived from registers; there is no combinational path from inputs to outputs.
- detected held high for several cycles is treated as one event per cycle.

Test Plan:
1. Single event, no backpressure:
   - Stimulus: rst, then detected=1 only in cycle 5, ts_ready=1.
   - Required: cycle 6 shows ts_valid=1, ts_data=5, fifo_level=1, count=1; cycle 7 shows ts_valid=0, ts_data=0.
2. Overflow with DEPTH=4:
   - Stimulus: ts_ready=0; detected=1 in cycles 2,3,4,5,6,7.
   - Required: fifo_level=4, count=6, overflow=1.
   - Drain with ts_ready=1: ts_data sequence 2,3,4,5, then ts_valid=0; overflow stays 1.
3. Full FIFO, simultaneous push/pop:
   - Stimulus: FIFO holds 4 entries; detected=1 and ts_ready=1 in the same cycle.
   - Required: fifo_level stays 4, overflow stays 0, the head advances, and the new timestamp becomes the tail.
4. Count saturation (CNT_W=3):
   - Stimulus: 9 detections.
   - Required: count=7 after the 7th detection and stays 7.
   - clear without detected gives count=0; clear together with detected gives count=1.
5. Timestamp wrap (TS_W=4):
   - Stimulus: events in cycles 15, 16 and 17 after reset.
   - Required: ts_data sequence 15, 0, 1.
6. Reset mid-drain:
   - Stimulus: FIFO holds 3 entries, overflow=1, count=5; assert rst for 1 cycle with detected=1.
   - Required: next cycle shows all outputs 0 and fifo_level=0; the next event is timestamped from 0.

Source files
------------

// File: rtl/detect_event_logger.sv
// Purpose: timestamps each detector strobe with a free-running cycle counter and
// queues the timestamps in a small first-word-fall-through FIFO drained over
// valid/ready. It also keeps a saturating detection count and a sticky overflow
// flag that records when an event was dropped because the FIFO was full.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   detected   detection strobe, one event per cycle it is high
//   clear      synchronous clear of count and overflow (FIFO untouched)
//   ts_valid   FIFO non-empty; ts_data holds the oldest entry
//   ts_ready   consumer accept; pop when ts_valid && ts_ready
//   ts_data    head timestamp, 0 when empty
//   fifo_level number of stored entries, 0..DEPTH
//   count      saturating detection count since reset/clear
//   overflow   sticky dropped-event flag
module detect_event_logger #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     detected,
    input  logic                     clear,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [TS_W-1:0]          ts_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [TS_W-1:0]  ts_cnt;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             pop;
    logic             push;
    logic             drop;
    logic             full;
    logic [LVL_W-1:0] level_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;

    // Handshake decode; a pop frees the slot so a push into a full FIFO still lands.
    always_comb begin
        full      = (level == LVL_W'(DEPTH));
        pop       = (level != '0) && ts_ready;
        push      = detected && (!full || pop);
        drop      = detected && full && !pop;
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LVL_W'(1);
        end
        cnt_nxt = cnt;
        if (clear) begin
            cnt_nxt = detected ? CNT_W'(1) : '0;
        end else if (detected && (cnt != {CNT_W{1'b1}})) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        ovf_nxt = clear ? drop : (ovf | drop);
    end

    // Control state: counter, pointers, level and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            level <= level_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Storage needs no reset: its contents are only visible while level is non-zero.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= ts_cnt;
        end
    end

    // Outputs decode registered state only.
    assign ts_valid   = (level != '0);
    assign ts_data    = ts_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;
    assign count      = cnt;
    assign overflow   = ovf;

endmodule

// File: tb/tb_detect_event_logger.sv
module tb_detect_event_logger;

    localparam int TSW   = 4;
    localparam int DEP   = 4;
    localparam int CW    = 3;
    localparam int TSMOD = 1 << TSW;
    localparam int CMAX  = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           detected = 1'b0;
    logic           clear = 1'b0;
    logic           ts_ready = 1'b0;
    logic           ts_valid;
    logic [TSW-1:0] ts_data;
    logic [$clog2(DEP):0] fifo_level;
    logic [CW-1:0]  count;
    logic           overflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    int q[$];
    int m_ts  = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    typedef struct {
        logic r, d, c, y;
        int   ev, ed, el, ec, eo;
    } vec_t;

    vec_t tbl[11];

    detect_event_logger #(.TS_W(TSW), .DEPTH(DEP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .detected(detected), .clear(clear),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data),
        .fifo_level(fifo_level), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rules applied directly: pop happens first, then push if there is room.
    task automatic model_step(input logic r, input logic d, input logic c, input logic y);
        bit dropped;
        dropped = 1'b0;
        if (r) begin
            q.delete();
            m_ts  = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            if (q.size() > 0 && y) void'(q.pop_front());
            if (d) begin
                if (q.size() < DEP) q.push_back(m_ts);
                else dropped = 1'b1;
            end
            if (c) m_cnt = d ? 1 : 0;
            else if (d && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_ovf = c ? dropped : (m_ovf | dropped);
            m_ts  = (m_ts + 1) % TSMOD;
        end
    endtask

    task automatic cmp_model();
        chk("model_valid", int'(ts_valid), (q.size() != 0) ? 1 : 0);
        chk("model_data", int'(ts_data), (q.size() != 0) ? q[0] : 0);
        chk("model_level", int'(fifo_level), q.size());
        chk("model_count", int'(count), m_cnt);
        chk("model_overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic cyc(input logic r, input logic d, input logic c, input logic y);
        rst = r; detected = d; clear = c; ts_ready = y;
        @(posedge clk);
        model_step(r, d, c, y);
        #1;
        cmp_model();
    endtask

    task automatic drain_expect(input string name, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            chk({name, "_valid"}, int'(ts_valid), 1);
            chk({name, "_data"}, int'(ts_data), (first + k) % TSMOD);
            cyc(0, 0, 0, 1);
        end
        chk({name, "_empty_valid"}, int'(ts_valid), 0);
        chk({name, "_empty_data"}, int'(ts_data), 0);
    endtask

    initial begin
        // single event at cycle 5, then clear behaviour
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 5, 1, 1, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 8, 1, 1, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1, 0};

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].r, tbl[i].d, tbl[i].c, tbl[i].y);
            chk("tbl_valid", int'(ts_valid), tbl[i].ev);
            chk("tbl_data", int'(ts_data), tbl[i].ed);
            chk("tbl_level", int'(fifo_level), tbl[i].el);
            chk("tbl_count", int'(count), tbl[i].ec);
            chk("tbl_overflow", int'(overflow), tbl[i].eo);
        end

        // overflow: events in cycles 2..7 with no consumer
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int c = 2; c <= 7; c++) cyc(0, 1, 0, 0);
        chk("ovf_level", int'(fifo_level), 4);
        chk("ovf_count", int'(count), 6);
        chk("ovf_flag", int'(overflow), 1);
        drain_expect("ovf_drain", 2, 4);
        chk("ovf_sticky", int'(overflow), 1);

        // full FIFO with simultaneous push and pop
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 4; c++) cyc(0, 1, 0, 0);
        chk("full_level", int'(fifo_level), 4);
        chk("full_head", int'(ts_data), 0);
        cyc(0, 1, 0, 1);
        chk("pp_level", int'(fifo_level), 4);
        chk("pp_overflow", int'(overflow), 0);
        chk("pp_head", int'(ts_data), 1);
        drain_expect("pp_drain", 1, 4);

        // count saturation and clear
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 1, 0, 1);
            chk("sat_count", int'(count), (i < CMAX) ? i : CMAX);
        end
        chk("sat_overflow", int'(overflow), 0);
        cyc(0, 0, 1, 0);
        chk("clr_count", int'(count), 0);
        cyc(0, 1, 1, 0);
        chk("clr_det_count", int'(count), 1);

        // timestamp wrap: events in cycles 15, 16, 17
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 15; c++) cyc(0, 0, 0, 0);
        for (int c = 0; c < 3; c++) cyc(0, 1, 0, 0);
        chk("wrap_level", int'(fifo_level), 3);
        drain_expect("wrap_drain", 15, 3);

        // reset in the middle of draining
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 5; c++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        chk("mid_level", int'(fifo_level), 3);
        chk("mid_count", int'(count), 5);
        chk("mid_overflow", int'(overflow), 1);
        cyc(1, 1, 0, 1);
        chk("rst_valid", int'(ts_valid), 0);
        chk("rst_data", int'(ts_data), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        cyc(0, 1, 0, 0);
        chk("post_rst_valid", int'(ts_valid), 1);
        chk("post_rst_ts", int'(ts_data), 0);

        // randomized traffic with varying consumer pressure
        cyc(1, 0, 0, 0);
        for (int w = 0; w < 30; w++) begin
            int rdy_pct;
            rdy_pct = int'($urandom_range(0, 100));
            for (int i = 0; i < 100; i++) begin
                logic r, d, c, y;
                r = ($urandom_range(0, 199) == 0);
                c = ($urandom_range(0, 29) == 0);
                d = ($urandom_range(0, 99) < 60);
                y = (int'($urandom_range(0, 99)) < rdy_pct);
                cyc(r, d, c, y);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
